// File: rtl/bsg_dff_gatestack_sync.sv
`default_nettype none
// ============================================================================
//  Module   : bsg_dff_gatestack_sync
//  Purpose  : Single-clock per-channel strobe capture. Each channel's strobe
//             is treated as a data-qualified event: strobe and data are
//             synchronized into clk_i, the selected strobe edge is detected,
//             and the aligned data bit is captured and held for a
//             valid/yumi consumer.
//  Ports    : clk_i      - sole clock, all state updates on posedge
//             reset_n_i  - synchronous reset, active-low
//             data_i     - per-channel data bit sampled with its strobe
//             strobe_i   - per-channel capture strobe (may be asynchronous)
//             data_o     - last captured data bit per channel
//             v_o        - per-channel captured-and-unconsumed flag
//             yumi_i     - per-channel consume, honoured only where v_o=1
//             overrun_o  - per-channel sticky: capture while still unconsumed
//  Revision : 1.0 - initial release
// ============================================================================
module bsg_dff_gatestack_sync #(
    parameter int width_p       = 16,
    parameter int sync_stages_p = 2,
    parameter int edge_mode_p   = 0
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic [width_p-1:0] data_i,
    input  logic [width_p-1:0] strobe_i,
    output logic [width_p-1:0] data_o,
    output logic [width_p-1:0] v_o,
    input  logic [width_p-1:0] yumi_i,
    output logic [width_p-1:0] overrun_o
);

    // Synchronizer chains. Data travels through the same depth as the
    // strobe so the bit leaving the last data stage is the one that was
    // sampled together with the strobe edge now leaving the last strobe stage.
    logic [width_p-1:0] r_strobe_sync [sync_stages_p];
    logic [width_p-1:0] r_data_sync   [sync_stages_p];
    logic [width_p-1:0] r_strobe_prev;

    logic [width_p-1:0] r_data;
    logic [width_p-1:0] r_v;
    logic [width_p-1:0] r_overrun;

    logic [width_p-1:0] w_strobe_last;
    logic [width_p-1:0] w_data_last;
    logic [width_p-1:0] w_rise;
    logic [width_p-1:0] w_fall;
    logic [width_p-1:0] w_ev;
    logic [width_p-1:0] w_accept;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            for (int k = 0; k < sync_stages_p; k++) begin
                r_strobe_sync[k] <= '0;
                r_data_sync[k]   <= '0;
            end
            r_strobe_prev <= '0;
        end else begin
            r_strobe_sync[0] <= strobe_i;
            r_data_sync[0]   <= data_i;
            for (int k = 1; k < sync_stages_p; k++) begin
                r_strobe_sync[k] <= r_strobe_sync[k-1];
                r_data_sync[k]   <= r_data_sync[k-1];
            end
            r_strobe_prev <= r_strobe_sync[sync_stages_p-1];
        end
    end

    assign w_strobe_last = r_strobe_sync[sync_stages_p-1];
    assign w_data_last   = r_data_sync[sync_stages_p-1];

    assign w_rise = w_strobe_last & ~r_strobe_prev;
    assign w_fall = ~w_strobe_last & r_strobe_prev;

    generate
        if (edge_mode_p == 0) begin : g_mode_rise
            assign w_ev = w_rise;
        end else if (edge_mode_p == 1) begin : g_mode_fall
            assign w_ev = w_fall;
        end else begin : g_mode_both
            assign w_ev = w_rise | w_fall;
        end
    endgenerate

    // A yumi against an empty channel is ignored entirely.
    assign w_accept = yumi_i & r_v;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_data    <= '0;
            r_v       <= '0;
            r_overrun <= '0;
        end else begin
            r_data <= (w_ev & w_data_last) | (~w_ev & r_data);
            r_v    <= w_ev | (r_v & ~w_accept);
            // Accepting the old value always clears the sticky flag, even
            // when a new capture lands in the same cycle; otherwise it is
            // set by a capture that would overwrite an unconsumed value.
            r_overrun <= ~w_accept & (r_overrun | (w_ev & r_v));
        end
    end

    assign data_o    = r_data;
    assign v_o       = r_v;
    assign overrun_o = r_overrun;

endmodule
`default_nettype wire
